// File: rtl/panda_risc_v_reg_file_rd_arb_if.sv
// Bundle of requester and physical register-file read-port signals for the read arbiter.
// The arbiter uses modport slave; the requesters and the register file use modport master.
interface panda_risc_v_reg_file_rd_arb_if;
  logic        ifu_reg_file_rd_req;
  logic [4:0]  ifu_reg_file_rd_addr;
  logic        ifu_reg_file_rd_grant;
  logic [31:0] ifu_reg_file_rd_dout;

  logic        dcd_reg_file_rd_p0_req;
  logic [4:0]  dcd_reg_file_rd_p0_addr;
  logic        dcd_reg_file_rd_p0_grant;
  logic [31:0] dcd_reg_file_rd_p0_dout;

  logic        dcd_reg_file_rd_p1_req;
  logic [4:0]  dcd_reg_file_rd_p1_addr;
  logic        dcd_reg_file_rd_p1_grant;
  logic [31:0] dcd_reg_file_rd_p1_dout;

  logic        dbg_reg_file_rd_req;
  logic [4:0]  dbg_reg_file_rd_addr;
  logic        dbg_reg_file_rd_grant;
  logic [31:0] dbg_reg_file_rd_dout;

  logic [4:0]  reg_file_rd_p0_addr;
  logic [31:0] reg_file_rd_p0_dout;
  logic [4:0]  reg_file_rd_p1_addr;
  logic [31:0] reg_file_rd_p1_dout;

  modport master (
    output ifu_reg_file_rd_req, ifu_reg_file_rd_addr,
    output dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    output dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    output dbg_reg_file_rd_req, dbg_reg_file_rd_addr,
    output reg_file_rd_p0_dout, reg_file_rd_p1_dout,
    input  ifu_reg_file_rd_grant, ifu_reg_file_rd_dout,
    input  dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    input  dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    input  dbg_reg_file_rd_grant, dbg_reg_file_rd_dout,
    input  reg_file_rd_p0_addr, reg_file_rd_p1_addr
  );

  modport slave (
    input  ifu_reg_file_rd_req, ifu_reg_file_rd_addr,
    input  dcd_reg_file_rd_p0_req, dcd_reg_file_rd_p0_addr,
    input  dcd_reg_file_rd_p1_req, dcd_reg_file_rd_p1_addr,
    input  dbg_reg_file_rd_req, dbg_reg_file_rd_addr,
    input  reg_file_rd_p0_dout, reg_file_rd_p1_dout,
    output ifu_reg_file_rd_grant, ifu_reg_file_rd_dout,
    output dcd_reg_file_rd_p0_grant, dcd_reg_file_rd_p0_dout,
    output dcd_reg_file_rd_p1_grant, dcd_reg_file_rd_p1_dout,
    output dbg_reg_file_rd_grant, dbg_reg_file_rd_dout,
    output reg_file_rd_p0_addr, reg_file_rd_p1_addr
  );
endinterface

// File: rtl/panda_risc_v_reg_file_rd_arb.sv
// Register-file read-port arbiter: fixed priority per physical port with a starvation guard.
// Optional performance counters are enabled by defining PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN.
module panda_risc_v_reg_file_rd_arb #(
  parameter real simulation_delay = 1,
  parameter int  DCD_STARVE_THR   = 4,
  parameter int  DBG_STARVE_THR   = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic sys_reset_req,
  input  logic flush_req,
  panda_risc_v_reg_file_rd_arb_if.slave rd
`ifdef PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_p0_conflict_cnt,
  output logic [31:0] perf_p1_conflict_cnt,
  output logic [31:0] perf_force_grant_cnt
`endif
);

  localparam logic [3:0] DCD_THR = 4'(DCD_STARVE_THR);
  localparam logic [3:0] DBG_THR = 4'(DBG_STARVE_THR);

  logic [3:0] dcd0_wait_cnt;
  logic [3:0] dbg_wait_cnt;
  logic       dcd0_force;
  logic       dbg_force;
  logic       ifu_grant;
  logic       dcd0_grant;
  logic       dcd1_grant;
  logic       dbg_grant;
  logic       arb_clr;

  assign dcd0_force = rd.dcd_reg_file_rd_p0_req & (dcd0_wait_cnt == DCD_THR);
  assign dbg_force  = rd.dbg_reg_file_rd_req & (dbg_wait_cnt == DBG_THR);

  // Grants are forced low while reset is asserted, independent of the counters.
  assign ifu_grant  = resetn & rd.ifu_reg_file_rd_req & ~dcd0_force;
  assign dcd0_grant = resetn & rd.dcd_reg_file_rd_p0_req & (dcd0_force | ~rd.ifu_reg_file_rd_req);
  assign dcd1_grant = resetn & rd.dcd_reg_file_rd_p1_req & ~dbg_force;
  assign dbg_grant  = resetn & rd.dbg_reg_file_rd_req & (dbg_force | ~rd.dcd_reg_file_rd_p1_req);

  assign rd.ifu_reg_file_rd_grant    = ifu_grant;
  assign rd.dcd_reg_file_rd_p0_grant = dcd0_grant;
  assign rd.dcd_reg_file_rd_p1_grant = dcd1_grant;
  assign rd.dbg_reg_file_rd_grant    = dbg_grant;

  assign rd.reg_file_rd_p0_addr = ifu_grant ? rd.ifu_reg_file_rd_addr : rd.dcd_reg_file_rd_p0_addr;
  assign rd.reg_file_rd_p1_addr = dbg_grant ? rd.dbg_reg_file_rd_addr : rd.dcd_reg_file_rd_p1_addr;

  assign rd.ifu_reg_file_rd_dout    = rd.reg_file_rd_p0_dout;
  assign rd.dcd_reg_file_rd_p0_dout = rd.reg_file_rd_p0_dout;
  assign rd.dcd_reg_file_rd_p1_dout = rd.reg_file_rd_p1_dout;
  assign rd.dbg_reg_file_rd_dout    = rd.reg_file_rd_p1_dout;

  assign arb_clr = sys_reset_req | flush_req;

  // Only the low-priority requester on each port tracks how long it has been denied.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dcd0_wait_cnt <= 4'd0;
    end else if (arb_clr || dcd0_grant || !rd.dcd_reg_file_rd_p0_req) begin
      dcd0_wait_cnt <= 4'd0;
    end else if (dcd0_wait_cnt < DCD_THR) begin
      dcd0_wait_cnt <= dcd0_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dbg_wait_cnt <= 4'd0;
    end else if (arb_clr || dbg_grant || !rd.dbg_reg_file_rd_req) begin
      dbg_wait_cnt <= 4'd0;
    end else if (dbg_wait_cnt < DBG_THR) begin
      dbg_wait_cnt <= dbg_wait_cnt + 4'd1;
    end
  end

`ifdef PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN
  // Perf counters ignore flush/system reset so they survive pipeline events.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_p0_conflict_cnt <= 32'd0;
      perf_p1_conflict_cnt <= 32'd0;
      perf_force_grant_cnt <= 32'd0;
    end else begin
      if (rd.ifu_reg_file_rd_req && rd.dcd_reg_file_rd_p0_req)
        perf_p0_conflict_cnt <= perf_p0_conflict_cnt + 32'd1;
      if (rd.dcd_reg_file_rd_p1_req && rd.dbg_reg_file_rd_req)
        perf_p1_conflict_cnt <= perf_p1_conflict_cnt + 32'd1;
      if (dcd0_force || dbg_force)
        perf_force_grant_cnt <= perf_force_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_panda_risc_v_reg_file_rd_arb.sv
// Scoreboard bench for the register-file read arbiter: directed cycles push expected
// grants/addresses/data into a queue, a monitor pops and compares on each falling edge.
module tb_panda_risc_v_reg_file_rd_arb;

  typedef struct {
    logic [3:0]  gnt;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          tag;
  } exp_t;

  logic clk;
  logic resetn;
  logic sys_reset_req;
  logic flush_req;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   vec_cnt   = 0;

  panda_risc_v_reg_file_rd_arb_if rd_if ();

`ifdef PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN
  logic [31:0] perf_p0_conflict_cnt;
  logic [31:0] perf_p1_conflict_cnt;
  logic [31:0] perf_force_grant_cnt;
`endif

  panda_risc_v_reg_file_rd_arb #(
    .DCD_STARVE_THR(4),
    .DBG_STARVE_THR(8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sys_reset_req(sys_reset_req),
    .flush_req    (flush_req),
    .rd           (rd_if)
`ifdef PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN
    ,
    .perf_p0_conflict_cnt(perf_p0_conflict_cnt),
    .perf_p1_conflict_cnt(perf_p1_conflict_cnt),
    .perf_force_grant_cnt(perf_force_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                             input logic [31:0] exp_v);
    check_cnt++;
    if (act !== exp_v) begin
      fail_cnt++;
      $display("[TB] FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, tag, act, exp_v);
    end else begin
      pass_cnt++;
    end
  endtask

  // req bit order: {ifu, dcd_p0, dcd_p1, dbg}; eg uses the same order for grants.
  task automatic applyStimulus(input logic rn, input logic sr, input logic fl,
                               input logic [3:0] req, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [3:0] eg,
                               input logic [4:0] ea0, input logic [4:0] ea1);
    exp_t e;
    @(posedge clk);
    #1;
    resetn                        = rn;
    sys_reset_req                 = sr;
    flush_req                     = fl;
    rd_if.ifu_reg_file_rd_req     = req[3];
    rd_if.dcd_reg_file_rd_p0_req  = req[2];
    rd_if.dcd_reg_file_rd_p1_req  = req[1];
    rd_if.dbg_reg_file_rd_req     = req[0];
    rd_if.reg_file_rd_p0_dout     = d0;
    rd_if.reg_file_rd_p1_dout     = d1;
    e.gnt = eg;
    e.a0  = ea0;
    e.a1  = ea1;
    e.d0  = d0;
    e.d1  = d1;
    e.tag = vec_cnt;
    vec_cnt++;
    exp_q.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 32'h11, 32'hDEADBEEF, 4'b0000, 5'd7, 5'd9);
  endtask

  // Monitor: every falling edge with a pending expectation is compared against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("grant", e.tag, {28'd0, rd_if.ifu_reg_file_rd_grant,
                    rd_if.dcd_reg_file_rd_p0_grant, rd_if.dcd_reg_file_rd_p1_grant,
                    rd_if.dbg_reg_file_rd_grant}, {28'd0, e.gnt});
        checkOutput("p0_addr", e.tag, {27'd0, rd_if.reg_file_rd_p0_addr}, {27'd0, e.a0});
        checkOutput("p1_addr", e.tag, {27'd0, rd_if.reg_file_rd_p1_addr}, {27'd0, e.a1});
        checkOutput("ifu_dout", e.tag, rd_if.ifu_reg_file_rd_dout, e.d0);
        checkOutput("dcd0_dout", e.tag, rd_if.dcd_reg_file_rd_p0_dout, e.d0);
        checkOutput("dcd1_dout", e.tag, rd_if.dcd_reg_file_rd_p1_dout, e.d1);
        checkOutput("dbg_dout", e.tag, rd_if.dbg_reg_file_rd_dout, e.d1);
      end
    end
  end

  initial begin
    resetn                        = 1'b0;
    sys_reset_req                 = 1'b0;
    flush_req                     = 1'b0;
    rd_if.ifu_reg_file_rd_req     = 1'b0;
    rd_if.dcd_reg_file_rd_p0_req  = 1'b0;
    rd_if.dcd_reg_file_rd_p1_req  = 1'b0;
    rd_if.dbg_reg_file_rd_req     = 1'b0;
    rd_if.ifu_reg_file_rd_addr    = 5'd5;
    rd_if.dcd_reg_file_rd_p0_addr = 5'd7;
    rd_if.dcd_reg_file_rd_p1_addr = 5'd9;
    rd_if.dbg_reg_file_rd_addr    = 5'd3;
    rd_if.reg_file_rd_p0_dout     = 32'h11;
    rd_if.reg_file_rd_p1_dout     = 32'hDEADBEEF;

    // Reset with every requester active: no grants at all.
    repeat (2)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 32'h11, 32'hDEADBEEF, 4'b0000, 5'd7, 5'd9);
    // First cycle after release: high-priority requesters win both ports.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 32'h11, 32'hDEADBEEF, 4'b1010, 5'd5, 5'd9);
    idleCycle();

    // IFU vs decoder p0: decoder forced in on every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9)
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1100, 32'h11, 32'hDEADBEEF, 4'b0100, 5'd7, 5'd9);
      else
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1100, 32'h11, 32'hDEADBEEF, 4'b1000, 5'd5, 5'd9);
    end
    idleCycle();

`ifdef PANDA_RISC_V_RF_RD_ARB_PERF_CNT_EN
    // Release cycle contributed one conflict on each port before the 10 conflict cycles.
    @(negedge clk);
    checkOutput("perf_p0_conflict", vec_cnt, perf_p0_conflict_cnt, 32'd11);
    checkOutput("perf_p1_conflict", vec_cnt, perf_p1_conflict_cnt, 32'd1);
    checkOutput("perf_force_grant", vec_cnt, perf_force_grant_cnt, 32'd2);
`endif

    // Debug alone on port 1.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 32'h0, 32'hDEADBEEF, 4'b0001, 5'd7, 5'd3);
    idleCycle();

    // Decoder p1 vs debug: debug only gets in once its counter reaches 8.
    for (int i = 0; i < 12; i++) begin
      if (i == 8)
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0011, 32'h11, 32'hCAFEF00D, 4'b0001, 5'd7, 5'd3);
      else
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0011, 32'h11, 32'hCAFEF00D, 4'b0010, 5'd7, 5'd9);
    end
    idleCycle();

    // Flush after three denials restarts the decoder p0 wait.
    for (int i = 0; i < 9; i++) begin
      if (i == 8)
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1100, 32'h55, 32'h0, 4'b0100, 5'd7, 5'd9);
      else
        applyStimulus(1'b1, 1'b0, (i == 3), 4'b1100, 32'h55, 32'h0, 4'b1000, 5'd5, 5'd9);
    end
    idleCycle();

    // System reset request after two denials also restarts the wait.
    for (int i = 0; i < 8; i++) begin
      if (i == 7)
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1100, 32'h66, 32'h0, 4'b0100, 5'd7, 5'd9);
      else
        applyStimulus(1'b1, (i == 2), 1'b0, 4'b1100, 32'h66, 32'h0, 4'b1000, 5'd5, 5'd9);
    end
    idleCycle();

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
        check_cnt++;
        fail_cnt++;
        $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
